dev_ram_dumper: RTL and testbench
=================================

DEV_RAM_DUMPER -- requirements
Module: dev_ram_dumper

Interface
REQ-001 Parameter LINE_BYTES, default 16, bytes printed per output line (1..255).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low: sampled on the rising edge of clk, reset when 0.
REQ-004 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-005 base_addr  input  16  first RAM byte address; captured on accepted start.
REQ-006 len  input  16  number of bytes to dump; captured on accepted start.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse when the dump completes.
REQ-009 ram_rd  output  1  one-cycle RAM read strobe.
REQ-010 ram_addr  output  16  RAM byte address, valid while ram_rd is high.
REQ-011 ram_rdata  input  8  RAM read data, valid exactly 1 cycle after ram_rd.
REQ-012 putc_en  input  1  UART output buffer can accept a character.
REQ-013 putc_push  output  1  one-cycle push of putc_char into the UART output buffer.
REQ-014 putc_char  output  8  ASCII character, valid while putc_push is high.

Function
REQ-015 Output format per line: 4 uppercase hex address digits, ':', then per byte ' ' plus 2 uppercase hex digits, then CR (0x0D) and LF (0x0A).
REQ-016 A line break is issued after every LINE_BYTES bytes counted from base_addr, and after the last byte; line breaks are not tied to address alignment.
REQ-017 The line address is the address of the first byte on that line, modulo 2^16.
REQ-018 States: IDLE, ADDR3, ADDR2, ADDR1, ADDR0, COLON, RD, RD_WAIT, SPACE, HI, LO, CR, LF, FIN.
REQ-019 IDLE: start=1 with len≠0 captures base_addr and len and enters ADDR3.
REQ-020 IDLE: start=1 with len=0 enters FIN, so no character is pushed.
REQ-021 Character states (ADDRx, COLON, SPACE, HI, LO, CR, LF) assert putc_push only in a cycle where putc_en=1, then advance; with putc_en=0 they hold state and keep putc_push=0.
REQ-022 ADDR3..ADDR0 emit address nibbles [15:12]..[3:0]; COLON then goes to RD.
REQ-023 RD asserts ram_rd for 1 cycle with the current address; RD_WAIT latches ram_rdata into a byte register, then goes to SPACE.
REQ-024 SPACE->HI->LO; LO increments the address (16-bit wrap, 0xFFFF->0x0000), decrements the remaining count, and increments the line byte counter.
REQ-025 After LO: remaining=0 or line counter=LINE_BYTES goes to CR; otherwise goes to RD.
REQ-026 LF: remaining=0 goes to FIN; otherwise clears the line counter and goes to ADDR3.
REQ-027 FIN pulses done for 1 cycle and returns to IDLE; busy=0 in FIN and IDLE.
REQ-028 start while busy is ignored; the captured base_addr and len are unaffected.
REQ-029 At most one putc_push per cycle; putc_push and ram_rd are never high in the same cycle.
REQ-030 Nibble to ASCII: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46.

Reset
REQ-031 While rst=0: state=IDLE, busy=0, done=0, ram_rd=0, putc_push=0, putc_char=0, ram_addr=0, and all counters and the byte register are 0.
REQ-032 rst=0 mid-dump aborts on the next edge; the partial line is not completed and done is not pulsed.

Structure
REQ-033 The state enum and the ASCII constants (CR, LF, ':', ' ') belong in package pkg_dumper; the address width comes from pkg_ram.
REQ-034 One combinational sub-module, hex_ascii (4-bit nibble in, 8-bit ASCII out), is instantiated once.
REQ-035 The top level connects putc_* to the if_io client side and ram_* to a dev_ram_switch slot.

Verification
REQ-036 base=0x0010, len=3, RAM={A5,00,FF}, putc_en=1 -> 16 pushes "0010: A5 00 FF\r\n", then one done pulse.
REQ-037 base=0x0000, len=17 -> line "0000:" with 16 bytes + CRLF, then "0010: xx\r\n"; 17 ram_rd pulses in total.
REQ-038 len=0 -> no putc_push and no ram_rd; done pulses 2 cycles after start; busy never rises.
REQ-039 putc_en toggling 0/1 every cycle -> same character sequence as REQ-036, with no push while putc_en=0.
REQ-040 base=0xFFFF, len=2, RAM[FFFF]=11, RAM[0000]=22 -> "FFFF: 11 22\r\n"; ram_addr sequence FFFF, 0000.
REQ-041 rst=0 after 5 characters of a dump, then start base=0x0100 len=1 -> fresh "0100: xx\r\n"; no done pulse for the aborted dump.

Source files
------------

// File: rtl/dev_ram_dumper_pkg.sv
// Shared constants for the RAM hex dumper.
// Address width lives with the RAM; states and ASCII live with the dumper.
package pkg_ram;
  localparam int ADDR_W = 16;
endpackage

package pkg_dumper;
  import pkg_ram::*;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ADDR3   = 4'd1;
  localparam logic [3:0] S_ADDR2   = 4'd2;
  localparam logic [3:0] S_ADDR1   = 4'd3;
  localparam logic [3:0] S_ADDR0   = 4'd4;
  localparam logic [3:0] S_COLON   = 4'd5;
  localparam logic [3:0] S_RD      = 4'd6;
  localparam logic [3:0] S_RD_WAIT = 4'd7;
  localparam logic [3:0] S_SPACE   = 4'd8;
  localparam logic [3:0] S_HI      = 4'd9;
  localparam logic [3:0] S_LO      = 4'd10;
  localparam logic [3:0] S_CR      = 4'd11;
  localparam logic [3:0] S_LF      = 4'd12;
  localparam logic [3:0] S_FIN     = 4'd13;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
endpackage

// File: rtl/dev_ram_dumper_if.sv
// Dumper bundle: control, RAM read port and UART putc port.
// master = dumper side, slave = RAM/UART/controller side.
interface dev_ram_dumper_if;
  import pkg_ram::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       len;
  logic              busy;
  logic              done;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata;
  logic              putc_en;
  logic              putc_push;
  logic [7:0]        putc_char;

  modport master (
    input  start, base_addr, len,
    input  ram_rdata, putc_en,
    output busy, done,
    output ram_rd, ram_addr,
    output putc_push, putc_char
  );

  modport slave (
    output start, base_addr, len,
    output ram_rdata, putc_en,
    input  busy, done,
    input  ram_rd, ram_addr,
    input  putc_push, putc_char
  );
endinterface

// File: rtl/dev_ram_dumper_hex_ascii.sv
// Nibble to uppercase ASCII hex digit.
// 0-9 -> '0'-'9', A-F -> 'A'-'F'.
module hex_ascii (
  input  logic [3:0] nib,
  output logic [7:0] asc
);
  always_comb begin
    if (nib < 4'd10) asc = {4'h3, nib};
    else             asc = {4'h0, nib} + 8'h37;
  end
endmodule

// File: rtl/dev_ram_dumper.sv
// RAM hex dumper: reads bytes and prints "AAAA: xx xx..\r\n" lines.
// One character per cycle when the UART buffer accepts it.
module dev_ram_dumper
  import pkg_ram::*;
  import pkg_dumper::*;
#(
  parameter int LINE_BYTES = 16
) (
  input logic clk,
  input logic rst,
  dev_ram_dumper_if.master bus
);
  localparam logic [7:0] LB = 8'(LINE_BYTES);

  logic [3:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       remaining;
  logic [7:0]        line_cnt;
  logic [7:0]        data;
  logic              done_q;

  logic [3:0] nib;
  logic [7:0] hex_c;
  logic [7:0] chr;
  logic       is_chr;
  logic       push;

  always_comb begin
    nib = 4'h0;
    unique case (state)
      S_ADDR3: nib = addr[15:12];
      S_ADDR2: nib = addr[11:8];
      S_ADDR1: nib = addr[7:4];
      S_ADDR0: nib = addr[3:0];
      S_HI:    nib = data[7:4];
      S_LO:    nib = data[3:0];
      default: nib = 4'h0;
    endcase
  end

  hex_ascii u_hex (
    .nib (nib),
    .asc (hex_c)
  );

  always_comb begin
    chr    = 8'h00;
    is_chr = 1'b1;
    unique case (state)
      S_ADDR3, S_ADDR2,
      S_ADDR1, S_ADDR0,
      S_HI, S_LO: chr = hex_c;
      S_COLON:    chr = CH_COLON;
      S_SPACE:    chr = CH_SPACE;
      S_CR:       chr = CH_CR;
      S_LF:       chr = CH_LF;
      default:    is_chr = 1'b0;
    endcase
  end

  // outputs are gated by rst so an abort silences them immediately
  assign push          = rst & is_chr & bus.putc_en;
  assign bus.putc_push = push;
  assign bus.putc_char = push ? chr : 8'h00;
  assign bus.ram_rd    = rst & (state == S_RD);
  assign bus.ram_addr  = rst ? addr : '0;
  assign bus.busy      = rst & (state != S_IDLE)
                       & (state != S_FIN);
  assign bus.done      = rst & done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      line_cnt  <= '0;
      data      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == S_FIN);
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.len == 16'd0) begin
              state <= S_FIN;
            end else begin
              addr      <= bus.base_addr;
              remaining <= bus.len;
              line_cnt  <= '0;
              state     <= S_ADDR3;
            end
          end
        end
        S_ADDR3: if (bus.putc_en) state <= S_ADDR2;
        S_ADDR2: if (bus.putc_en) state <= S_ADDR1;
        S_ADDR1: if (bus.putc_en) state <= S_ADDR0;
        S_ADDR0: if (bus.putc_en) state <= S_COLON;
        S_COLON: if (bus.putc_en) state <= S_RD;
        S_RD:    state <= S_RD_WAIT;
        S_RD_WAIT: begin
          data  <= bus.ram_rdata;
          state <= S_SPACE;
        end
        S_SPACE: if (bus.putc_en) state <= S_HI;
        S_HI:    if (bus.putc_en) state <= S_LO;
        S_LO: begin
          if (bus.putc_en) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 16'd1;
            line_cnt  <= line_cnt + 8'd1;
            if (remaining == 16'd1 ||
                (line_cnt + 8'd1) == LB)
              state <= S_CR;
            else
              state <= S_RD;
          end
        end
        S_CR: if (bus.putc_en) state <= S_LF;
        S_LF: begin
          if (bus.putc_en) begin
            if (remaining == 16'd0) begin
              state <= S_FIN;
            end else begin
              line_cnt <= '0;
              state    <= S_ADDR3;
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dev_ram_dumper.sv
// Randomized bench for dev_ram_dumper against a text-level dump model.
// RAM contents live in a bench array; expected text built per dump.
module tb_dev_ram_dumper;
  localparam int LB = 16;
  typedef logic [7:0] bq_t[$];

  logic clk;
  logic rst;
  dev_ram_dumper_if bus();

  dev_ram_dumper #(.LINE_BYTES(LB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [7:0]  cq [$];
  logic [15:0] aq [$];
  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int done_cnt, done_cyc, busy_cnt, rd_cnt, push_cnt;
  int en_mode = 0;
  logic pend = 1'b0;
  logic [15:0] pend_a = '0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    return (n < 4'd10) ? 8'(48 + int'(n)) : 8'(55 + int'(n));
  endfunction

  // the whole dump as text, straight from the line format rules
  function automatic bq_t fmt(input logic [15:0] b, input int n);
    bq_t s;
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + 16'(i);
      if (i % LB == 0) begin
        s.push_back(hx(a[15:12])); s.push_back(hx(a[11:8]));
        s.push_back(hx(a[7:4]));   s.push_back(hx(a[3:0]));
        s.push_back(8'h3A);
      end
      s.push_back(8'h20);
      s.push_back(hx(mem[a][7:4]));
      s.push_back(hx(mem[a][3:0]));
      if (i % LB == LB - 1 || i == n - 1) begin
        s.push_back(8'h0D);
        s.push_back(8'h0A);
      end
    end
    return s;
  endfunction

  function automatic bit qeq(input bq_t q, input string lit);
    if (q.size() != lit.len()) return 1'b0;
    for (int i = 0; i < q.size(); i++)
      if (q[i] != lit[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    #1;
    case (en_mode)
      0:       bus.putc_en = 1'b1;
      1:       bus.putc_en = ~bus.putc_en;
      default: bus.putc_en = ($urandom % 4) != 0;
    endcase
  end

  always @(negedge clk) begin
    bus.ram_rdata = pend ? mem[pend_a] : 8'($urandom);
    pend   = bus.ram_rd;
    pend_a = bus.ram_addr;
  end

  always @(negedge clk) begin
    cyc++;
    if (bus.busy) busy_cnt++;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.ram_rd) begin
      rd_cnt++;
      chk("rd_busy", bus.busy, 1);
      if (aq.size() == 0) chk("rd_extra", 1, 0);
      else chk("ram_addr", bus.ram_addr, aq.pop_front());
    end
    if (bus.putc_push) begin
      push_cnt++;
      chk("push_en", bus.putc_en, 1);
      chk("push_busy", bus.busy, 1);
      chk("push_rd", bus.ram_rd, 0);
      if (cq.size() == 0) chk("push_extra", 1, 0);
      else chk("putc_char", bus.putc_char, cq.pop_front());
    end else begin
      chk("char_idle", bus.putc_char, 0);
    end
  end

  task automatic load(input logic [15:0] b, input int n);
    bq_t s;
    s = fmt(b, n);
    cq.delete();
    aq.delete();
    foreach (s[i]) cq.push_back(s[i]);
    for (int i = 0; i < n; i++) aq.push_back(b + 16'(i));
    done_cnt = 0; busy_cnt = 0; rd_cnt = 0; push_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic kick(input logic [15:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.base_addr = b;
    bus.len = l;
  endtask

  task automatic dump(input logic [15:0] b, input logic [15:0] l);
    int st, t, nch;
    load(b, int'(l));
    nch = cq.size();
    kick(b, l);
    st = cyc + 1;
    @(posedge clk); #1;
    t = 0;
    while (done_cnt == 0 && t < 5000) begin
      bus.start = bus.busy && ($urandom % 3 == 0);
      bus.base_addr = 16'($urandom);
      bus.len = 16'($urandom);
      @(posedge clk); #1;
      t++;
    end
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_cnt", done_cnt, 1);
    chk("chars_left", cq.size(), 0);
    chk("push_cnt", push_cnt, nch);
    chk("rd_cnt", rd_cnt, int'(l));
    chk("busy_end", bus.busy, 0);
    if (l == 16'd0) begin
      chk("done_lat", done_cyc - st, 2);
      chk("busy_len0", busy_cnt, 0);
    end
  endtask

  initial begin
    bq_t s;
    int t;
    logic [15:0] b;
    int l;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.len = '0;
    bus.putc_en = 1'b1;
    bus.ram_rdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd", bus.ram_rd, 0);
    chk("rst_push", bus.putc_push, 0);
    chk("rst_addr", bus.ram_addr, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    mem[16'h0010] = 8'hA5; mem[16'h0011] = 8'h00; mem[16'h0012] = 8'hFF;
    s = fmt(16'h0010, 3);
    chk("model_a5", qeq(s, "0010: A5 00 FF\r\n"), 1);
    dump(16'h0010, 16'd3);

    s = fmt(16'h0000, 17);
    chk("model_len17", s.size(), 65);
    dump(16'h0000, 16'd17);

    dump(16'h1234, 16'd0);

    en_mode = 1;
    dump(16'h0010, 16'd3);
    en_mode = 0;

    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    s = fmt(16'hFFFF, 2);
    chk("model_wrap", qeq(s, "FFFF: 11 22\r\n"), 1);
    dump(16'hFFFF, 16'd2);

    load(16'h0200, 20);
    kick(16'h0200, 16'd20);
    @(posedge clk); #1;
    bus.start = 1'b0;
    t = 0;
    while (push_cnt < 5 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_pushes", push_cnt, 5);
    chk("abort_busy", bus.busy, 0);
    chk("abort_push", bus.putc_push, 0);
    cq.delete();
    aq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_done", done_cnt, 0);
    chk("abort_pushes2", push_cnt, 5);
    dump(16'h0100, 16'd1);

    for (int k = 0; k < 12; k++) begin
      en_mode = k % 3;
      b = 16'($urandom);
      if (k % 4 == 0) l = LB * (1 + k / 4);
      else l = $urandom_range(1, 40);
      for (int i = 0; i < l; i++) mem[b + 16'(i)] = 8'($urandom);
      dump(b, 16'(l));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end
endmodule
